// File: rtl/modulation_segment_0_with_control_if.sv
// rtl/modulation_segment_0_with_control_if.sv - frame bus for the segment modulator; output_parity present only with MOD_PARITY_EN
interface modulation_segment_0_with_control_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] segment_0;
  logic [WIDTH-1:0] segment_1;
  logic [WIDTH-1:0] segment_2;
  logic [WIDTH-1:0] segment_3;
  logic [WIDTH-1:0] segment_4;
  logic [WIDTH-1:0] segment_5;
  logic [WIDTH-1:0] segment_6;
  logic [WIDTH-1:0] segment_7;
  logic [WIDTH-1:0] segment_8;
  logic [WIDTH-1:0] segment_9;
  logic [WIDTH-1:0] output_bit;
  logic             out_valid;
  logic [3:0]       seg_index;
  logic             valid;
  logic             busy;
`ifdef MOD_PARITY_EN
  logic             output_parity;
`endif

  modport master (
    output start,
    output segment_0, segment_1, segment_2, segment_3, segment_4,
    output segment_5, segment_6, segment_7, segment_8, segment_9,
    input  output_bit, out_valid, seg_index, valid, busy
`ifdef MOD_PARITY_EN
    , input output_parity
`endif
  );

  modport slave (
    input  start,
    input  segment_0, segment_1, segment_2, segment_3, segment_4,
    input  segment_5, segment_6, segment_7, segment_8, segment_9,
    output output_bit, out_valid, seg_index, valid, busy
`ifdef MOD_PARITY_EN
    , output output_parity
`endif
  );
endinterface

// File: rtl/modulation_segment_0_with_control.sv
// rtl/modulation_segment_0_with_control.sv - differential segment modulator with start/valid/busy handshake; MOD_PARITY_EN adds output_parity
module modulation_segment_0_with_control #(
  parameter int               WIDTH   = 32,
  parameter int               NUM_SEG = 10,
  parameter int               LATENCY = 3,
  parameter logic [WIDTH-1:0] SEED    = '0
) (
  input logic clk,
  input logic reset,
  modulation_segment_0_with_control_if.slave bus
);
  // fill counter only needs to reach LATENCY-2
  localparam int FW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, FILL, SEND, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] seg_in [NUM_SEG];
  logic [WIDTH-1:0] bank   [NUM_SEG];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] word_d;
  logic [FW-1:0]    fill_q;
  logic [3:0]       idx_q;
  logic [WIDTH-1:0] obit_q;
  logic             ovalid_q;
  logic [3:0]       sidx_q;
  logic             valid_q;

  assign seg_in[0] = bus.segment_0;
  assign seg_in[1] = bus.segment_1;
  assign seg_in[2] = bus.segment_2;
  assign seg_in[3] = bus.segment_3;
  assign seg_in[4] = bus.segment_4;
  assign seg_in[5] = bus.segment_5;
  assign seg_in[6] = bus.segment_6;
  assign seg_in[7] = bus.segment_7;
  assign seg_in[8] = bus.segment_8;
  assign seg_in[9] = bus.segment_9;

  assign bus.output_bit = obit_q;
  assign bus.out_valid  = ovalid_q;
  assign bus.seg_index  = sidx_q;
  assign bus.valid      = valid_q;
  assign bus.busy       = ~valid_q;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state: dropping start anywhere in a frame returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = (LATENCY == 1) ? SEND : FILL;
      FILL: begin
        if (!bus.start)                        state_d = IDLE;
        else if (fill_q == FW'(LATENCY - 2))   state_d = SEND;
      end
      SEND: begin
        if (!bus.start)                        state_d = IDLE;
        else if (idx_q == 4'(NUM_SEG))         state_d = DONE;
      end
      DONE: if (!bus.start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // next modulated word; idx_q reaches NUM_SEG only on the DONE transition
  always_comb begin
    word_d = '0;
    if (idx_q < 4'(NUM_SEG)) word_d = bank[idx_q] ^ prev_q;
  end

  // capture bank, chain words, drive registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SEG; i++) bank[i] <= '0;
      prev_q   <= '0;
      fill_q   <= '0;
      idx_q    <= '0;
      obit_q   <= '0;
      ovalid_q <= 1'b0;
      sidx_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          obit_q   <= '0;
          ovalid_q <= 1'b0;
          sidx_q   <= '0;
          valid_q  <= 1'b0;
          if (bus.start) begin
            for (int i = 0; i < NUM_SEG; i++) bank[i] <= seg_in[i];
            prev_q <= SEED;
            fill_q <= '0;
            idx_q  <= '0;
          end
        end
        FILL: begin
          if (bus.start) fill_q <= fill_q + FW'(1);
          else           sidx_q <= '0;
        end
        SEND: begin
          if (!bus.start) begin
            obit_q   <= '0;
            ovalid_q <= 1'b0;
            sidx_q   <= '0;
          end else if (idx_q == 4'(NUM_SEG)) begin
            obit_q   <= '0;
            ovalid_q <= 1'b0;
            valid_q  <= 1'b1;
          end else begin
            obit_q   <= word_d;
            prev_q   <= word_d;
            ovalid_q <= 1'b1;
            sidx_q   <= idx_q;
            idx_q    <= idx_q + 4'd1;
          end
        end
        DONE: begin
          if (!bus.start) begin
            valid_q <= 1'b0;
            sidx_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MOD_PARITY_EN
  logic parity_q;
  assign bus.output_parity = parity_q;

  // parity registered alongside the word it covers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                                   parity_q <= 1'b0;
    else if (state_q == SEND && bus.start && idx_q < 4'(NUM_SEG)) parity_q <= ^word_d;
    else                                                          parity_q <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_modulation_segment_0_with_control.sv
// tb/tb_modulation_segment_0_with_control.sv - self-checking bench for modulation_segment_0_with_control
module tb_modulation_segment_0_with_control;
  localparam int W = 32;
  localparam int L = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  modulation_segment_0_with_control_if #(.WIDTH(W)) bus ();

  modulation_segment_0_with_control #(
    .WIDTH(W), .NUM_SEG(10), .LATENCY(L), .SEED(32'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [W-1:0] seg [10];
  assign bus.segment_0 = seg[0];
  assign bus.segment_1 = seg[1];
  assign bus.segment_2 = seg[2];
  assign bus.segment_3 = seg[3];
  assign bus.segment_4 = seg[4];
  assign bus.segment_5 = seg[5];
  assign bus.segment_6 = seg[6];
  assign bus.segment_7 = seg[7];
  assign bus.segment_8 = seg[8];
  assign bus.segment_9 = seg[9];

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // frame model: a frame is the cumulative XOR of the captured segments, played out
  // L edges after capture, one word per edge, then valid until start falls
  int mode = 0;        // 0 idle, 1 frame running, 2 frame complete
  int n = 0;           // edges since capture
  logic [W-1:0] mw [10];
  logic [W-1:0] acc;

  always @(posedge clk or negedge reset) begin
    if (!reset) mode = 0;
    else begin
      case (mode)
        0: if (bus.start) begin
          acc = 32'h0;
          for (int k = 0; k < 10; k++) begin
            acc = acc ^ seg[k];
            mw[k] = acc;
          end
          n = 0;
          mode = 1;
        end
        1: if (!bus.start) mode = 0;
           else begin
             n++;
             if (n == L + 10) mode = 2;
           end
        default: if (!bus.start) mode = 0;
      endcase
    end
  end

  logic [W-1:0] got_q [$];
  logic         e_ov, e_v;
  logic [W-1:0] e_w;
  logic [3:0]   e_ix;

  // compare every cycle against the model
  always @(negedge clk) begin
    e_ov = 1'b0; e_w = '0; e_ix = 4'd0; e_v = 1'b0;
    if (mode == 1 && n >= L) begin
      e_ov = 1'b1;
      e_w  = mw[n - L];
      e_ix = 4'(n - L);
    end else if (mode == 2) begin
      e_v  = 1'b1;
      e_ix = 4'd9;
    end
    chk("out_valid", bus.out_valid, e_ov);
    chk("output_bit", bus.output_bit, e_w);
    chk("seg_index", bus.seg_index, e_ix);
    chk("valid", bus.valid, e_v);
    chk("busy", bus.busy, !e_v);
`ifdef MOD_PARITY_EN
    chk("output_parity", bus.output_parity, e_ov ? ^e_w : 1'b0);
`endif
    if (bus.out_valid === 1'b1) got_q.push_back(bus.output_bit);
  end

  // raise start and time the frame in negedges after the raise
  task automatic run_frame(input bit scramble, output int t_first, output int t_valid);
    got_q.delete();
    @(negedge clk);
    bus.start = 1'b1;
    t_first = -1;
    t_valid = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (scramble) for (int k = 0; k < 10; k++) seg[k] = $urandom;
      if (bus.out_valid === 1'b1 && t_first < 0) t_first = c;
      if (bus.valid === 1'b1) begin
        t_valid = c;
        break;
      end
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_frame1(input string tag);
    logic [W-1:0] lit [10];
    lit = '{32'd1, 32'd3, 32'd0, 32'd4, 32'd1, 32'd7, 32'd0, 32'd8, 32'd1, 32'd11};
    chk({tag, "_count"}, 32'(got_q.size()), 32'd10);
    if (got_q.size() == 10)
      for (int k = 0; k < 10; k++) chk({tag, "_word"}, got_q[k], lit[k]);
  endtask

  task automatic set_ramp();
    for (int k = 0; k < 10; k++) seg[k] = 32'(k + 1);
  endtask

  int tf, tv;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    for (int k = 0; k < 10; k++) seg[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b1);
    chk("rst_valid", bus.valid, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // ramp payload, latency and completion timing
    set_ramp();
    run_frame(1'b0, tf, tv);
    chk("t1_first_word_delay", 32'(tf), 32'd4);
    chk("t1_valid_delay", 32'(tv), 32'd14);
    chk_frame1("t1");
    // start held after completion: no retrigger
    repeat (4) begin
      @(negedge clk);
      chk("t1_hold_valid", bus.valid, 1'b1);
    end
    end_frame();

    // abort after a few words, then restart from word 0
    for (int k = 0; k < 10; k++) seg[k] = $urandom;
    @(negedge clk);
    bus.start = 1'b1;
    repeat (5) @(negedge clk);
    bus.start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t3_abort_valid", bus.valid, 1'b0);
    end
    run_frame(1'b0, tf, tv);
    chk("t3_restart_word0", got_q.size() > 0 ? got_q[0] : 32'hx, seg[0]);
    chk("t3_restart_delay", 32'(tf), 32'd4);
    end_frame();

    // async reset mid-SEND, then frame 1 again
    set_ramp();
    @(negedge clk);
    bus.start = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t4_rst_out_valid", bus.out_valid, 1'b0);
    chk("t4_rst_output_bit", bus.output_bit, 32'h0);
    chk("t4_rst_seg_index", 32'(bus.seg_index), 32'd0);
    chk("t4_rst_busy", bus.busy, 1'b1);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_frame(1'b0, tf, tv);
    chk_frame1("t4");
    end_frame();

    // segments churn after capture
    set_ramp();
    run_frame(1'b1, tf, tv);
    chk_frame1("t5");
    end_frame();

    // all-ones payload alternates 1,0,1,0
    for (int k = 0; k < 10; k++) seg[k] = 32'h1;
    run_frame(1'b0, tf, tv);
    chk("t6_count", 32'(got_q.size()), 32'd10);
    if (got_q.size() == 10)
      for (int k = 0; k < 10; k++) chk("t6_word", got_q[k], (k % 2 == 0) ? 32'h1 : 32'h0);
    end_frame();

    // random payloads over many frames
    for (int f = 0; f < 100; f++) begin
      for (int k = 0; k < 10; k++) seg[k] = $urandom;
      run_frame(1'b0, tf, tv);
      chk("t2_valid_delay", 32'(tv), 32'd14);
      end_frame();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
